rf_wb_arbiter: RTL

Shares the register file's single write port between two writeback requesters: the ALU writeback path (port A) and the memory/load writeback path (port M). Each requester gets a small FIFO. A round-robin arbiter drains one entry per cycle into a registered write command (`rf_wr`/`rf_waddr`/`rf_wdata`), which drives the register file's `wr`/`addr3`/`data3` inputs. The block also exports a pending-write mask so the issue stage can stall on read-after-write hazards.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 78 +++++++
 rtl/rf_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared datapath definitions: register-file geometry, well-known register
// numbers and the writeback arbiter's round-robin state type.
package mips_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_AT   = 5'd1;
  localparam logic [REG_AW-1:0] REG_V0   = 5'd2;
  localparam logic [REG_AW-1:0] REG_A0   = 5'd4;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_M = 1'b1
  } rr_state_e;

  function automatic logic [NUM_REGS-1:0] reg_decode(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] d;
    d    = {NUM_REGS{1'b0}};
    d[r] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small writeback request FIFO; also exports per-entry valid/address so the
// owner can build a pending-write mask without popping.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [REG_AW-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  output logic                      full,
  output logic                      empty,
  output logic [REG_AW-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH*REG_AW-1:0]   ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       count_r;
  logic [REG_AW-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic              do_push_s;
  logic              do_pop_s;
  logic [PW-1:0]     offset_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == (PW+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      addr_mem_r[wr_ptr_r] <= push_addr;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    offset_s  = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset_s                       = PW'(i) - rd_ptr_r;
      ent_valid[i]                   = ({1'b0, offset_s} < count_r);
      ent_addr[i*REG_AW +: REG_AW]   = addr_mem_r[i];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the register file's
// single write port, with a registered write command and a pending-write mask.
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [REG_AW-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [REG_AW-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_data,
  input  logic                flush,
  output logic                rf_wr,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic                    a_full_s, a_empty_s, m_full_s, m_empty_s;
  logic [REG_AW-1:0]       a_head_addr_s, m_head_addr_s, grant_addr_s;
  logic [DATA_W-1:0]       a_head_data_s, m_head_data_s, grant_data_s;
  logic [DEPTH-1:0]        a_ent_valid_s, m_ent_valid_s;
  logic [DEPTH*REG_AW-1:0] a_ent_addr_s, m_ent_addr_s;
  logic                    grant_a_s, grant_m_s, grant_s;
  logic [NUM_REGS-1:0]     mask_s;
  rr_state_e               state_r, state_nxt_s;

  assign a_ready = !a_full_s;
  assign m_ready = !m_full_s;
  assign grant_s = grant_a_s || grant_m_s;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .flush(flush),
    .push(a_valid && !flush), .pop(grant_a_s),
    .push_addr(a_addr), .push_data(a_data),
    .full(a_full_s), .empty(a_empty_s),
    .head_addr(a_head_addr_s), .head_data(a_head_data_s),
    .ent_valid(a_ent_valid_s), .ent_addr(a_ent_addr_s)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_m (
    .clk(clk), .rst(rst), .flush(flush),
    .push(m_valid && !flush), .pop(grant_m_s),
    .push_addr(m_addr), .push_data(m_data),
    .full(m_full_s), .empty(m_empty_s),
    .head_addr(m_head_addr_s), .head_data(m_head_data_s),
    .ent_valid(m_ent_valid_s), .ent_addr(m_ent_addr_s)
  );

  // Round-robin preference register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= PREF_A;
    else     state_r <= state_nxt_s;
  end

  // Grant selection; nothing is granted during a flush so the pointer holds.
  always_comb begin
    grant_a_s   = 1'b0;
    grant_m_s   = 1'b0;
    state_nxt_s = state_r;
    if (!flush) begin
      case (state_r)
        PREF_A: begin
          if (!a_empty_s)      grant_a_s = 1'b1;
          else if (!m_empty_s) grant_m_s = 1'b1;
          else                 grant_a_s = 1'b0;
        end
        PREF_M: begin
          if (!m_empty_s)      grant_m_s = 1'b1;
          else if (!a_empty_s) grant_a_s = 1'b1;
          else                 grant_m_s = 1'b0;
        end
        default: begin
          grant_a_s = 1'b0;
          grant_m_s = 1'b0;
        end
      endcase
    end else begin
      grant_a_s = 1'b0;
      grant_m_s = 1'b0;
    end
    if (grant_a_s)      state_nxt_s = PREF_M;
    else if (grant_m_s) state_nxt_s = PREF_A;
    else                state_nxt_s = state_r;
  end

  // Head of the granted FIFO.
  always_comb begin
    grant_addr_s = a_head_addr_s;
    grant_data_s = a_head_data_s;
    if (grant_m_s) begin
      grant_addr_s = m_head_addr_s;
      grant_data_s = m_head_data_s;
    end else begin
      grant_addr_s = a_head_addr_s;
      grant_data_s = a_head_data_s;
    end
  end

  // Registered write command; $zero writes are consumed without a write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= 32'd0;
    end else begin
      rf_wr <= grant_s && (grant_addr_s != REG_ZERO);
      if (grant_s) begin
        rf_waddr <= grant_addr_s;
        rf_wdata <= grant_data_s;
      end
    end
  end

  // Pending-write mask over queued entries plus the write being presented.
  always_comb begin
    mask_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_valid_s[i]) mask_s = mask_s | reg_decode(a_ent_addr_s[i*REG_AW +: REG_AW]);
      else                  mask_s = mask_s;
      if (m_ent_valid_s[i]) mask_s = mask_s | reg_decode(m_ent_addr_s[i*REG_AW +: REG_AW]);
      else                  mask_s = mask_s;
    end
    if (rf_wr) mask_s = mask_s | reg_decode(rf_waddr);
    else       mask_s = mask_s;
    mask_s[0] = 1'b0;
  end

  assign pend_mask = mask_s;

endmodule
